mem_load_return: RTL and testbench
==================================

// Module: mem_load_return
// PURPOSE
// - Load-return stage directly downstream of the store/BRAM-port input logic.
// - Tracks each load through the 1-cycle BRAM port-B read, then selects the byte lane(s) for addr[1:0]/memSize.
// - Sign- or zero-extends the result and presents it, registered, to writeback with a valid strobe.
// - Returns the synchronised READ_REG_INPUT MMIO word instead of BRAM data when that address is read.
// PARAMETERS
// MEM_DISABLE    2'b00           memOp: no access
// MEM_READ_SEXT  2'b01           memOp: load, sign-extend
// MEM_READ_ZEXT  2'b10           memOp: load, zero-extend
// MEM_WRITE      2'b11           memOp: store (ignored here)
// BYTE/HALFWORD/WORD 2'b00/01/10 memSize encodings
// READ_REG_INPUT 32'h0200_0000   MMIO input register byte address (compare addr[31:2])
// PORTS
// clk           in   1   clock
// reset         in   1   asynchronous, active-high reset
// stall         in   1   writeback stall: hold all state, no new capture
// addr          in   32  load byte address, same cycle as memOp
// memOp         in   2   memory operation
// memSize       in   2   access size
// rdIn          in   5   destination register of the load
// doutB         in   32  BRAM port-B read data, little-endian, valid cycle after request
// mmioIn        in   32  asynchronous external input word
// loadValid     out  1   loadData/loadRd valid this cycle (1-cycle pulse per load)
// loadRd        out  5   destination register
// loadData      out  32  aligned, extended load result
// misalignTrap  out  1   misaligned load detected (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): loadValid=0, loadRd=0, loadData=0, misalignTrap=0, pending=0, held=0, sync regs=0.
// - Reset mid-operation: any in-flight load is dropped; no loadValid follows.
// - Stage 1 (edge N, stall=0): pending<=memOp is SEXT/ZEXT; latch op, size, off=addr[1:0], rdIn, isMmio=(addr[31:2]==READ_REG_INPUT[31:2]).
// - WRITE/DISABLE: pending<=0.
// - Stage 2 (edge N+1, stall=0): if pending, loadValid<=1, loadRd<=rd_q, loadData<=extend(select(src)); else loadValid<=0.
// - Load latency = 2 edges, request to loadValid. Back-to-back loads each cycle give one result per cycle.
// - src = isMmio ? mmioSync : (held ? rawHold : doutB).
// - Select: BYTE -> src[8*off+7 : 8*off]; HALFWORD -> off[1] ? src[31:16] : src[15:0]; WORD -> src.
// - Extend: SEXT replicates the selected MSB to bit 31; ZEXT fills zeros. WORD is unchanged.
// - Stall=1: stage-1 regs and outputs hold; loadValid stays at its current value (not re-pulsed).
// - On the first stalled edge with pending=1 and held=0: rawHold<=doutB, held<=1, because BRAM output may change during stall.
// - held clears on the first unstalled edge.
// - mmioIn passes through 2-flop synchroniser -> mmioSync. Reads see the value sampled >=2 edges earlier.
// - Simultaneous stall + new request: request ignored; upstream must hold it.
// - memSize=2'b11: treated as WORD.
// CONFIGURATION
// MISALIGN_TRAP_EN defined:
// - A load is misaligned when HALFWORD has off[0]=1 or WORD has off!=0.
// - Misaligned load: misalignTrap=1 in the loadValid cycle; loadValid=0; loadData holds its previous value.
// - misalignTrap resets to 0 and pulses for one cycle.
// MISALIGN_TRAP_EN undefined:
// - misalignTrap tied 0.
// - Misaligned offsets are truncated: HALFWORD uses off[1] only, WORD ignores off; loadValid asserts normally.
// TESTING
// - Word load addr=0x10, doutB=0x8899AABB -> 2 edges later loadValid=1, loadData=0x8899AABB, loadRd=rdIn.
// - Byte loads of doutB=0x80FF017F: SEXT off=3 -> 0xFFFFFF80; ZEXT off=3 -> 0x00000080; SEXT off=0 -> 0x0000007F.
// - Half load, doutB=0xCAFE1234: SEXT off=2 -> 0xFFFFCAFE; ZEXT off=0 -> 0x00001234.
// - Load, then stall 3 cycles with doutB changed to 0 -> result = original word; exactly one loadValid pulse.
// - mmioIn=0x12345678, wait 3 cycles, load addr=0x02000000 -> loadData=0x12345678.
// - Misaligned, reset and store checks:
//   - WORD load off=1 -> with MISALIGN_TRAP_EN, misalignTrap pulse and no loadValid; without it, loadValid with full word.
//   - Reset asserted the cycle after a load -> loadValid never asserts.
//   - Store -> no loadValid.

Source files
------------

// File: rtl/mem_load_return.sv
// Load-return stage: tracks loads through the 1-cycle BRAM read, aligns and extends the result.
// Optional misaligned-load trap enabled by defining MISALIGN_TRAP_EN.
module mem_load_return (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic [4:0]  rdIn,
  input  logic [31:0] doutB,
  input  logic [31:0] mmioIn,
  output logic        loadValid,
  output logic [4:0]  loadRd,
  output logic [31:0] loadData,
  output logic        misalignTrap
);

  localparam logic [1:0]  MEM_READ_SEXT  = 2'b01;
  localparam logic [1:0]  MEM_READ_ZEXT  = 2'b10;
  localparam logic [1:0]  BYTE           = 2'b00;
  localparam logic [1:0]  HALFWORD       = 2'b01;
  localparam logic [1:0]  WORD           = 2'b10;
  localparam logic [31:0] READ_REG_INPUT = 32'h0200_0000;

  logic        pending_q, pending_d;
  logic        sext_q, sext_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        mmio_q, mmio_d;
  logic        held_q, held_d;
  logic [31:0] raw_hold_q, raw_hold_d;
  logic [31:0] mmio_meta_q, mmio_sync_q;
  logic        valid_q, valid_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] data_q, data_d;

  logic [31:0] src_c;
  logic [31:0] shifted_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] result_c;

  // Source selection, lane alignment and sign/zero extension
  always_comb begin
    src_c     = mmio_q ? mmio_sync_q : (held_q ? raw_hold_q : doutB);
    shifted_c = src_c >> {off_q, 3'b000};
    byte_c    = shifted_c[7:0];
    half_c    = off_q[1] ? src_c[31:16] : src_c[15:0];
    result_c  = src_c;
    case (size_q)
      BYTE:     result_c = sext_q ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
      HALFWORD: result_c = sext_q ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
      WORD:     result_c = src_c;
      default:  result_c = src_c;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic misalign_c;

  always_comb begin
    misalign_c = ((size_q == HALFWORD) && off_q[0]) ||
                 (size_q[1] && (off_q != 2'b00));
  end
`endif

  // Next-state: everything holds under stall except the BRAM word capture
  always_comb begin
    pending_d  = pending_q;
    sext_d     = sext_q;
    size_d     = size_q;
    off_d      = off_q;
    rd_d       = rd_q;
    mmio_d     = mmio_q;
    held_d     = held_q;
    raw_hold_d = raw_hold_q;
    valid_d    = valid_q;
    rd_out_d   = rd_out_q;
    data_d     = data_q;
`ifdef MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    if (!stall) begin
      pending_d = (memOp == MEM_READ_SEXT) || (memOp == MEM_READ_ZEXT);
      sext_d    = (memOp == MEM_READ_SEXT);
      size_d    = memSize;
      off_d     = addr[1:0];
      rd_d      = rdIn;
      mmio_d    = (addr[31:2] == READ_REG_INPUT[31:2]);
      held_d    = 1'b0;
      valid_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_d    = 1'b0;
      if (pending_q && misalign_c) begin
        trap_d = 1'b1;
      end else if (pending_q) begin
`else
      if (pending_q) begin
`endif
        valid_d  = 1'b1;
        rd_out_d = rd_q;
        data_d   = result_c;
      end
    end else if (pending_q && !held_q) begin
      held_d     = 1'b1;
      raw_hold_d = doutB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      mmio_q      <= 1'b0;
      held_q      <= 1'b0;
      raw_hold_q  <= 32'h0;
      mmio_meta_q <= 32'h0;
      mmio_sync_q <= 32'h0;
      valid_q     <= 1'b0;
      rd_out_q    <= 5'd0;
      data_q      <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      pending_q   <= pending_d;
      sext_q      <= sext_d;
      size_q      <= size_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mmio_q      <= mmio_d;
      held_q      <= held_d;
      raw_hold_q  <= raw_hold_d;
      mmio_meta_q <= mmioIn;
      mmio_sync_q <= mmio_meta_q;
      valid_q     <= valid_d;
      rd_out_q    <= rd_out_d;
      data_q      <= data_d;
`ifdef MISALIGN_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  assign loadValid = valid_q;
  assign loadRd    = rd_out_q;
  assign loadData  = data_q;
`ifdef MISALIGN_TRAP_EN
  assign misalignTrap = trap_q;
`else
  assign misalignTrap = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_return.sv
// Directed bench for mem_load_return: alignment, extension, stall hold, MMIO, misalign, reset, store.
module tb_mem_load_return;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] addr;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic [4:0]  rdIn;
  logic [31:0] doutB;
  logic [31:0] mmioIn;
  logic        loadValid;
  logic [4:0]  loadRd;
  logic [31:0] loadData;
  logic        misalignTrap;

  int checks   = 0;
  int failures = 0;

  mem_load_return dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .addr         (addr),
    .memOp        (memOp),
    .memSize      (memSize),
    .rdIn         (rdIn),
    .doutB        (doutB),
    .mmioIn       (mmioIn),
    .loadValid    (loadValid),
    .loadRd       (loadRd),
    .loadData     (loadData),
    .misalignTrap (misalignTrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one load, present BRAM data the following cycle, check the result two edges later
  task automatic do_load(input string tag, input logic [1:0] op, input logic [1:0] size,
                         input logic [31:0] a, input logic [4:0] rd, input logic [31:0] dout,
                         input logic [31:0] exp_data);
    addr = a; memOp = op; memSize = size; rdIn = rd;
    tick();
    memOp = 2'b00; doutB = dout;
    check({tag, "_early"}, 32'(loadValid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(loadValid), 32'd1);
    check({tag, "_data"}, loadData, exp_data);
    check({tag, "_rd"}, 32'(loadRd), 32'(rd));
    tick();
    check({tag, "_pulse"}, 32'(loadValid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; addr = 32'h0; memOp = 2'b00; memSize = 2'b00;
    rdIn = 5'd0; doutB = 32'h0; mmioIn = 32'h0;
    tick(); tick();
    check("rst_valid", 32'(loadValid), 32'd0);
    check("rst_rd", 32'(loadRd), 32'd0);
    check("rst_data", loadData, 32'h0);
    check("rst_trap", 32'(misalignTrap), 32'd0);
    reset = 1'b0;
    tick();

    do_load("word", 2'b01, 2'b10, 32'h10, 5'd5, 32'h8899AABB, 32'h8899AABB);
    do_load("b_sx3", 2'b01, 2'b00, 32'h23, 5'd6, 32'h80FF017F, 32'hFFFFFF80);
    do_load("b_zx3", 2'b10, 2'b00, 32'h23, 5'd7, 32'h80FF017F, 32'h00000080);
    do_load("b_sx0", 2'b01, 2'b00, 32'h20, 5'd8, 32'h80FF017F, 32'h0000007F);
    do_load("b_zx1", 2'b10, 2'b00, 32'h21, 5'd9, 32'h80FF017F, 32'h00000001);
    do_load("b_sx2", 2'b01, 2'b00, 32'h22, 5'd10, 32'h80FF017F, 32'hFFFFFFFF);
    do_load("h_sx2", 2'b01, 2'b01, 32'h32, 5'd11, 32'hCAFE1234, 32'hFFFFCAFE);
    do_load("h_zx0", 2'b10, 2'b01, 32'h30, 5'd12, 32'hCAFE1234, 32'h00001234);
    do_load("h_zx2", 2'b10, 2'b01, 32'h32, 5'd13, 32'hCAFE1234, 32'h0000CAFE);
    do_load("sz11", 2'b01, 2'b11, 32'h40, 5'd14, 32'h87654321, 32'h87654321);

    // Back-to-back loads: one result per cycle
    addr = 32'h50; memOp = 2'b01; memSize = 2'b00; rdIn = 5'd1;
    tick();
    doutB = 32'h000000F0; addr = 32'h54; memOp = 2'b10; memSize = 2'b00; rdIn = 5'd2;
    tick();
    memOp = 2'b00; doutB = 32'h000000F1;
    check("b2b_a_valid", 32'(loadValid), 32'd1);
    check("b2b_a_data", loadData, 32'hFFFFFFF0);
    check("b2b_a_rd", 32'(loadRd), 32'd1);
    tick();
    check("b2b_b_valid", 32'(loadValid), 32'd1);
    check("b2b_b_data", loadData, 32'h000000F1);
    check("b2b_b_rd", 32'(loadRd), 32'd2);
    tick();
    check("b2b_end", 32'(loadValid), 32'd0);

    // Stall for three edges while BRAM output changes
    addr = 32'h60; memOp = 2'b01; memSize = 2'b10; rdIn = 5'd3;
    tick();
    memOp = 2'b00; doutB = 32'hA5A5_1234; stall = 1'b1;
    tick();
    doutB = 32'h0;
    check("stall_v1", 32'(loadValid), 32'd0);
    tick();
    check("stall_v2", 32'(loadValid), 32'd0);
    tick();
    check("stall_v3", 32'(loadValid), 32'd0);
    stall = 1'b0;
    tick();
    check("stall_valid", 32'(loadValid), 32'd1);
    check("stall_data", loadData, 32'hA5A5_1234);
    check("stall_rd", 32'(loadRd), 32'd3);
    tick();
    check("stall_pulse", 32'(loadValid), 32'd0);

    // MMIO input register read
    mmioIn = 32'h12345678;
    tick(); tick(); tick();
    do_load("mmio", 2'b10, 2'b10, 32'h0200_0000, 5'd4, 32'hDEADBEEF, 32'h12345678);

    // Misaligned word load
    addr = 32'h71; memOp = 2'b01; memSize = 2'b10; rdIn = 5'd15;
    tick();
    memOp = 2'b00; doutB = 32'h11223344;
    tick();
`ifdef MISALIGN_TRAP_EN
    check("mis_trap", 32'(misalignTrap), 32'd1);
    check("mis_valid", 32'(loadValid), 32'd0);
    check("mis_data_hold", loadData, 32'h12345678);
    tick();
    check("mis_trap_pulse", 32'(misalignTrap), 32'd0);
`else
    check("mis_trap", 32'(misalignTrap), 32'd0);
    check("mis_valid", 32'(loadValid), 32'd1);
    check("mis_data", loadData, 32'h11223344);
    tick();
    check("mis_pulse", 32'(loadValid), 32'd0);
`endif

    // Reset the cycle after a load: result is dropped
    addr = 32'h80; memOp = 2'b01; memSize = 2'b10; rdIn = 5'd16;
    tick();
    memOp = 2'b00; doutB = 32'h55AA55AA; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_v1", 32'(loadValid), 32'd0);
    check("rst_mid_data", loadData, 32'h0);
    tick();
    check("rst_mid_v2", 32'(loadValid), 32'd0);

    // Store produces no result
    addr = 32'h90; memOp = 2'b11; memSize = 2'b10; rdIn = 5'd17;
    tick();
    memOp = 2'b00; doutB = 32'h77777777;
    tick();
    check("store_v1", 32'(loadValid), 32'd0);
    tick();
    check("store_v2", 32'(loadValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
